// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine front panel and the WashingMachine block.
package wm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_RUN,
    ST_UNLOCK
  } wm_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int DELAY_W_DEF         = 8;
  localparam int TICK_DIV_DEF        = 10;
  localparam int UNLOCK_CYCLES_DEF   = 3;

endpackage

// File: rtl/wm_debounce.sv
// Synchronizes one raw panel input, debounces it and flags rising edges of the
// debounced level as a single-cycle registered pulse.
module wm_debounce #(
  parameter int CYCLES = wm_pkg::DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          prev_q;
  logic          press_q;

  // The level only flips after CYCLES consecutive disagreeing samples;
  // any agreeing sample restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
      press_q <= level_q & ~prev_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/wm_panel_ctrl.sv
// Front-panel controller: door interlock, optional delayed start and the
// start level that keeps WashingMachine running for a whole wash.
module wm_panel_ctrl
  import wm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DELAY_W         = DELAY_W_DEF,
  parameter int TICK_DIV        = TICK_DIV_DEF,
  parameter int UNLOCK_CYCLES   = UNLOCK_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_start_raw,
  input  logic               btn_cancel_raw,
  input  logic               door_closed_raw,
  input  logic [DELAY_W-1:0] delay_sel,
  input  logic               machine_done,
  output logic               start,
  output logic               door_lock,
  output logic               busy,
  output logic [DELAY_W-1:0] delay_remaining,
  output logic               err_door
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int UW = $clog2(UNLOCK_CYCLES + 1);

  logic start_press, start_level;
  logic cancel_press, cancel_level;
  logic door_closed, door_press;

  wm_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (btn_start_raw),
    .level_o (start_level),
    .press_o (start_press)
  );

  wm_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_cancel (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (btn_cancel_raw),
    .level_o (cancel_level),
    .press_o (cancel_press)
  );

  wm_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_door (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (door_closed_raw),
    .level_o (door_closed),
    .press_o (door_press)
  );

  logic unused_db;
  assign unused_db = &{1'b0, start_level, cancel_level, door_press};

  wm_state_e          state_q;
  logic               start_q, lock_q, busy_q, err_q;
  logic [DELAY_W-1:0] remain_q;
  logic [PW-1:0]      presc_q;
  logic [UW-1:0]      unlock_q;

  // Cancel outranks start in every state; in RUN all exit causes merge into
  // one UNLOCK transition, with err_door flagged whenever the door is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      lock_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      remain_q <= '0;
      presc_q  <= '0;
      unlock_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!cancel_press && start_press) begin
            if (!door_closed) begin
              err_q <= 1'b1;
            end else if (delay_sel == '0) begin
              state_q <= ST_RUN;
              start_q <= 1'b1;
              lock_q  <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q  <= ST_DELAY;
              remain_q <= delay_sel;
              presc_q  <= '0;
              lock_q   <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
        end
        ST_DELAY: begin
          if (cancel_press || !door_closed) begin
            err_q    <= ~cancel_press & ~door_closed;
            state_q  <= ST_IDLE;
            remain_q <= '0;
            lock_q   <= 1'b0;
            busy_q   <= 1'b0;
          end else if (presc_q == PW'(TICK_DIV - 1)) begin
            presc_q  <= '0;
            remain_q <= remain_q - DELAY_W'(1);
            if (remain_q == DELAY_W'(1)) begin
              state_q <= ST_RUN;
              start_q <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        ST_RUN: begin
          if (machine_done || cancel_press || !door_closed) begin
            state_q  <= ST_UNLOCK;
            start_q  <= 1'b0;
            unlock_q <= '0;
            err_q    <= ~door_closed;
          end
        end
        ST_UNLOCK: begin
          if (unlock_q == UW'(UNLOCK_CYCLES - 1)) begin
            state_q <= ST_IDLE;
            lock_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            unlock_q <= unlock_q + UW'(1);
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          start_q  <= 1'b0;
          lock_q   <= 1'b0;
          busy_q   <= 1'b0;
          remain_q <= '0;
        end
      endcase
    end
  end

  assign start           = start_q;
  assign door_lock       = lock_q;
  assign busy            = busy_q;
  assign err_door        = err_q;
  assign delay_remaining = remain_q;

endmodule
